// File: rtl/m_macstrobe8.sv
// m_macstrobe8: registered 8-way one-hot strobe sequencer (start index + burst length).
// Latency: LOAD sampled at edge n gives the first strobe on Q right after that edge; DONE follows the last strobe.
// Backpressure: HOLD freezes an active burst, ABORT kills it without DONE, and LOAD is ignored while ACTIVE.
//
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-high reset
//   SEL    [2:0] start line of the burst, sampled with LOAD
//   LEN    [2:0] burst length, sampled with LOAD (0 encodes 8)
//   LOAD   start request, honoured in IDLE or FINISH only
//   HOLD   freeze the active burst for one cycle per sampled-high edge
//   ABORT  terminate the active burst, no DONE
//   Q      [7:0] one-hot strobe lines, registered
//   BUSY   high while a burst is active
//   DONE   one-cycle pulse after the last strobe of a completed burst

module m_macstrobe8 (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [2:0] SEL,
   input  logic [2:0] LEN,
   input  logic       LOAD,
   input  logic       HOLD,
   input  logic       ABORT,
   output logic [7:0] Q,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] idx;
   logic [2:0] idx_nxt;
   logic [3:0] rem;
   logic [3:0] rem_nxt;

   logic [3:0] len_dec;
   logic       start;
   logic [7:0] q_nxt;
   logic       busy_nxt;
   logic       done_nxt;

   // LEN=0 encodes a full 8-strobe burst.
   assign len_dec = (LEN == 3'd0) ? 4'd8 : {1'b0, LEN};

   // Next-state and next-output logic. The outputs are computed from the
   // next state so that they can be registered and still line up with the
   // state they describe.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      rem_nxt   = rem;
      start     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (LOAD) begin
               start = 1'b1;
            end
         end

         ST_ACTIVE: begin
            // ABORT beats HOLD, which beats advance.
            if (ABORT) begin
               state_nxt = ST_IDLE;
            end else if (HOLD) begin
               state_nxt = ST_ACTIVE;
            end else if (rem == 4'd1) begin
               state_nxt = ST_FINISH;
            end else begin
               idx_nxt = idx + 3'd1;   // 3-bit add wraps 7 -> 0
               rem_nxt = rem - 4'd1;
            end
         end

         ST_FINISH: begin
            // A LOAD here chains straight into the next burst without an idle gap.
            if (LOAD) begin
               start = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (start) begin
         state_nxt = ST_ACTIVE;
         idx_nxt   = SEL;
         rem_nxt   = len_dec;
      end

      q_nxt    = 8'h00;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      if (state_nxt == ST_ACTIVE) begin
         q_nxt    = 8'h01 << idx_nxt;
         busy_nxt = 1'b1;
      end
      if (state_nxt == ST_FINISH) begin
         done_nxt = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
         idx   <= 3'd0;
         rem   <= 4'd0;
         Q     <= 8'h00;
         BUSY  <= 1'b0;
         DONE  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         rem   <= rem_nxt;
         Q     <= q_nxt;
         BUSY  <= busy_nxt;
         DONE  <= done_nxt;
      end
   end

endmodule

// File: tb/tb_m_macstrobe8.sv
// tb_m_macstrobe8: directed bench for m_macstrobe8 with a queue-based reference model.
// Latency: the model updates on the same edges as the DUT, and outputs are compared on every falling edge.
// Backpressure: HOLD/ABORT/LOAD are driven 1 time unit after the rising edge and held until the next one.

module tb_m_macstrobe8;

   logic       CLK;
   logic       RESET;
   logic [2:0] SEL;
   logic [2:0] LEN;
   logic       LOAD;
   logic       HOLD;
   logic       ABORT;
   logic [7:0] Q;
   logic       BUSY;
   logic       DONE;

   int checks;
   int failures;

   m_macstrobe8 dut (
      .CLK   (CLK),
      .RESET (RESET),
      .SEL   (SEL),
      .LEN   (LEN),
      .LOAD  (LOAD),
      .HOLD  (HOLD),
      .ABORT (ABORT),
      .Q     (Q),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: an accepted burst becomes a queue of the strobe
   // values still to be shown. The head is the strobe currently on Q.
   logic [7:0] mq[$];
   bit         mdone;

   always @(posedge CLK or posedge RESET) begin : model
      int         l;
      logic [2:0] p;
      if (RESET) begin
         mq.delete();
         mdone = 1'b0;
      end else if (mq.size() > 0) begin
         mdone = 1'b0;
         if (ABORT) begin
            mq.delete();
         end else if (!HOLD) begin
            void'(mq.pop_front());
            if (mq.size() == 0) mdone = 1'b1;
         end
      end else begin
         mdone = 1'b0;
         if (LOAD) begin
            l = (LEN == 3'd0) ? 8 : int'(LEN);
            for (int k = 0; k < l; k++) begin
               p = SEL + 3'(k);
               mq.push_back(8'h01 << p);
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge.
   always @(negedge CLK) begin : compare
      logic [7:0] eq;
      logic       eb;
      eq = (mq.size() > 0) ? mq[0] : 8'h00;
      eb = (mq.size() > 0);
      checks++;
      if (Q !== eq || BUSY !== eb || DONE !== mdone) begin
         failures++;
         $display("FAIL model_cmp t=%0t: got Q=%h BUSY=%b DONE=%b, want Q=%h BUSY=%b DONE=%b",
                  $time, Q, BUSY, DONE, eq, eb, mdone);
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic b, input logic d, input logic [7:0] q);
      checks++;
      if (Q !== q || BUSY !== b || DONE !== d) begin
         failures++;
         $display("FAIL %s: got Q=%h BUSY=%b DONE=%b, want Q=%h BUSY=%b DONE=%b",
                  name, Q, BUSY, DONE, q, b, d);
      end
   endtask

   task automatic start_burst(input logic [2:0] s, input logic [2:0] l);
      SEL  = s;
      LEN  = l;
      LOAD = 1'b1;
      step();
      LOAD = 1'b0;
   endtask

   logic [7:0] wrap_tbl [8];

   initial begin
      wrap_tbl[0] = 8'h40; wrap_tbl[1] = 8'h80; wrap_tbl[2] = 8'h01; wrap_tbl[3] = 8'h02;
      wrap_tbl[4] = 8'h04; wrap_tbl[5] = 8'h08; wrap_tbl[6] = 8'h10; wrap_tbl[7] = 8'h20;

      checks   = 0;
      failures = 0;
      RESET = 1'b1;
      SEL   = 3'd0;
      LEN   = 3'd0;
      LOAD  = 1'b0;
      HOLD  = 1'b0;
      ABORT = 1'b0;
      #1;
      chk("reset_state", 1'b0, 1'b0, 8'h00);
      repeat (2) @(posedge CLK);
      #2 RESET = 1'b0;
      step();
      chk("idle_after_reset", 1'b0, 1'b0, 8'h00);

      // HOLD/ABORT in IDLE do nothing.
      HOLD = 1'b1; ABORT = 1'b1;
      step();
      chk("idle_ignores_hold_abort", 1'b0, 1'b0, 8'h00);
      HOLD = 1'b0; ABORT = 1'b0;

      // Basic burst SEL=1 LEN=3.
      start_burst(3'd1, 3'd3);
      chk("basic_s1", 1'b1, 1'b0, 8'h02);
      step(); chk("basic_s2", 1'b1, 1'b0, 8'h04);
      step(); chk("basic_s3", 1'b1, 1'b0, 8'h08);
      step(); chk("basic_done", 1'b0, 1'b1, 8'h00);
      step(); chk("basic_idle", 1'b0, 1'b0, 8'h00);

      // Wrap and length 8.
      start_burst(3'd6, 3'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("wrap_s%0d", i), 1'b1, 1'b0, wrap_tbl[i]);
         step();
      end
      chk("wrap_done", 1'b0, 1'b1, 8'h00);
      step(); chk("wrap_idle", 1'b0, 1'b0, 8'h00);

      // HOLD for two cycles on the first strobe.
      start_burst(3'd0, 3'd2);
      chk("hold_s1a", 1'b1, 1'b0, 8'h01);
      HOLD = 1'b1;
      step(); chk("hold_s1b", 1'b1, 1'b0, 8'h01);
      step(); chk("hold_s1c", 1'b1, 1'b0, 8'h01);
      HOLD = 1'b0;
      step(); chk("hold_s2", 1'b1, 1'b0, 8'h02);
      step(); chk("hold_done", 1'b0, 1'b1, 8'h00);
      step(); chk("hold_idle", 1'b0, 1'b0, 8'h00);

      // Ignored LOAD mid-burst, then ABORT.
      start_burst(3'd3, 3'd4);
      chk("abort_s1", 1'b1, 1'b0, 8'h08);
      step(); chk("abort_s2", 1'b1, 1'b0, 8'h10);
      SEL = 3'd0; LEN = 3'd1; LOAD = 1'b1;
      step(); chk("abort_load_ignored", 1'b1, 1'b0, 8'h20);
      LOAD = 1'b0; ABORT = 1'b1;
      step(); chk("abort_cleared", 1'b0, 1'b0, 8'h00);
      ABORT = 1'b0;
      step(); chk("abort_no_done", 1'b0, 1'b0, 8'h00);

      // Back-to-back via LOAD in FINISH.
      start_burst(3'd5, 3'd1);
      chk("b2b_a1", 1'b1, 1'b0, 8'h20);
      step(); chk("b2b_a_done", 1'b0, 1'b1, 8'h00);
      SEL = 3'd0; LEN = 3'd2; LOAD = 1'b1;
      step(); chk("b2b_b1", 1'b1, 1'b0, 8'h01);
      LOAD = 1'b0;
      step(); chk("b2b_b2", 1'b1, 1'b0, 8'h02);
      step(); chk("b2b_b_done", 1'b0, 1'b1, 8'h00);
      step(); chk("b2b_idle", 1'b0, 1'b0, 8'h00);

      // Asynchronous reset mid-burst on the third strobe.
      start_burst(3'd2, 3'd5);
      chk("rst_s1", 1'b1, 1'b0, 8'h04);
      step(); chk("rst_s2", 1'b1, 1'b0, 8'h08);
      step(); chk("rst_s3", 1'b1, 1'b0, 8'h10);
      #1 RESET = 1'b1;
      #1 chk("rst_async", 1'b0, 1'b0, 8'h00);
      step(); step();
      #2 RESET = 1'b0;
      step(); chk("rst_idle1", 1'b0, 1'b0, 8'h00);
      step(); chk("rst_idle2", 1'b0, 1'b0, 8'h00);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
